// File: rtl/qif_spike_decoder.sv
// rtl/qif_spike_decoder.sv - windowed spike-rate and inter-spike-interval decoder
// Define QIF_SPIKE_DEC_ISI_EN to compile in the ISI FSM and the isi/isi_valid outputs.
module qif_spike_decoder #(
   parameter int WINDOW_LOG2 = 8,
   parameter int ISI_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             spike_in_i,
   output logic [7:0]       rate_o,
   output logic             rate_valid_o,
   output logic             rate_sat_o,
   output logic [ISI_W-1:0] isi_o,
   output logic             isi_valid_o
);

   logic                   spike_prev_q;
   logic                   spk_event;
   logic                   win_close;
   logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
   logic [8:0]             spk_cnt_q, spk_cnt_d;
   logic [8:0]             spk_sum;
   logic [7:0]             rate_q, rate_d;
   logic                   rate_valid_q, rate_valid_d;
   logic                   rate_sat_q, rate_sat_d;

   assign spk_event = spike_in_i & ~spike_prev_q;
   assign win_close = en_i & (&win_cnt_q);
   assign spk_sum   = spk_cnt_q + {8'd0, spk_event};

   // Resets high so a level already present at reset release is not an edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) spike_prev_q <= 1'b1;
      else          spike_prev_q <= spike_in_i;
   end

   always_comb begin
      win_cnt_d    = win_cnt_q;
      spk_cnt_d    = spk_cnt_q;
      rate_d       = rate_q;
      rate_sat_d   = rate_sat_q;
      rate_valid_d = 1'b0;
      if (clr_i) begin
         win_cnt_d = '0;
         spk_cnt_d = '0;
      end else if (en_i) begin
         win_cnt_d = win_cnt_q + WINDOW_LOG2'(1);
         if (win_close) begin
            rate_d       = (spk_sum > 9'd255) ? 8'd255 : spk_sum[7:0];
            rate_sat_d   = (spk_sum >= 9'd255);
            rate_valid_d = 1'b1;
            spk_cnt_d    = '0;
         end else begin
            spk_cnt_d = (spk_sum > 9'd255) ? 9'd255 : spk_sum;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         win_cnt_q    <= '0;
         spk_cnt_q    <= '0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
         rate_sat_q   <= 1'b0;
      end else begin
         win_cnt_q    <= win_cnt_d;
         spk_cnt_q    <= spk_cnt_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
         rate_sat_q   <= rate_sat_d;
      end
   end

   assign rate_o       = rate_q;
   assign rate_valid_o = rate_valid_q;
   assign rate_sat_o   = rate_sat_q;

`ifdef QIF_SPIKE_DEC_ISI_EN
   typedef enum logic {ISI_IDLE = 1'b0, ISI_ARMED = 1'b1} isi_state_e;

   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   isi_state_e       state_q, state_d;
   logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
   logic [ISI_W-1:0] isi_q, isi_d;
   logic             isi_valid_q, isi_valid_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ISI_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr_i)                  state_d = ISI_IDLE;
      else if (en_i && spk_event) state_d = ISI_ARMED;
   end

   // The first edge only arms the counter; intervals are reported from the second on.
   always_comb begin
      isi_cnt_d   = isi_cnt_q;
      isi_d       = isi_q;
      isi_valid_d = 1'b0;
      if (clr_i) begin
         isi_cnt_d = '0;
      end else if (en_i) begin
         case (state_q)
            ISI_IDLE: begin
               if (spk_event) isi_cnt_d = ISI_W'(1);
            end
            ISI_ARMED: begin
               if (spk_event) begin
                  isi_d       = isi_cnt_q;
                  isi_valid_d = 1'b1;
                  isi_cnt_d   = ISI_W'(1);
               end else if (isi_cnt_q != ISI_MAX) begin
                  isi_cnt_d = isi_cnt_q + ISI_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         isi_cnt_q   <= '0;
         isi_q       <= '0;
         isi_valid_q <= 1'b0;
      end else begin
         isi_cnt_q   <= isi_cnt_d;
         isi_q       <= isi_d;
         isi_valid_q <= isi_valid_d;
      end
   end

   assign isi_o       = isi_q;
   assign isi_valid_o = isi_valid_q;
`else
   assign isi_o       = '0;
   assign isi_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_qif_spike_decoder.sv
// tb/tb_qif_spike_decoder.sv - self-checking bench for qif_spike_decoder
// Two instances share stimulus: A (WINDOW_LOG2=4, ISI_W=16) and B (WINDOW_LOG2=10, ISI_W=4).
module tb_qif_spike_decoder;

   logic clk = 1'b0;
   logic rst_n, en, clr, spike;
   logic [7:0]  rate_a, rate_b;
   logic        rv_a, rv_b, sat_a, sat_b, iv_a, iv_b;
   logic [15:0] isi_a;
   logic [3:0]  isi_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   qif_spike_decoder #(.WINDOW_LOG2(4), .ISI_W(16)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .spike_in_i(spike),
      .rate_o(rate_a), .rate_valid_o(rv_a), .rate_sat_o(sat_a),
      .isi_o(isi_a), .isi_valid_o(iv_a)
   );

   qif_spike_decoder #(.WINDOW_LOG2(10), .ISI_W(4)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .spike_in_i(spike),
      .rate_o(rate_b), .rate_valid_o(rv_b), .rate_sat_o(sat_b),
      .isi_o(isi_b), .isi_valid_o(iv_b)
   );

   // Reference model: counts enabled cycles and events; interval = distance in enabled cycles.
   bit m_prev [2];
   int m_inwin[2];
   int m_tot  [2];
   int m_ecyc [2];
   int m_last [2];
   bit m_armed[2];
   int m_rate [2];
   bit m_sat  [2];
   bit m_rv   [2];
   int m_isi  [2];
   bit m_iv   [2];

   function automatic int win_len(int k);
      return (k == 0) ? 16 : 1024;
   endfunction

   function automatic int isi_max(int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   function automatic logic [26:0] exp_vec(int k);
      return {8'(m_rate[k]), m_rv[k], m_sat[k], 16'(m_isi[k]), m_iv[k]};
   endfunction

   function automatic logic [26:0] act_vec(int k);
      if (k == 0) return {rate_a, rv_a, sat_a, isi_a, iv_a};
      return {rate_b, rv_b, sat_b, 12'd0, isi_b, iv_b};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_prev[k] = 1'b1; m_inwin[k] = 0; m_tot[k] = 0; m_ecyc[k] = 0; m_last[k] = 0;
         m_armed[k] = 1'b0; m_rate[k] = 0; m_sat[k] = 1'b0; m_rv[k] = 1'b0;
         m_isi[k] = 0; m_iv[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit ev;
      int d;
      for (int k = 0; k < 2; k++) begin
         ev = spike && !m_prev[k];
         m_prev[k] = spike;
         m_rv[k] = 1'b0;
         m_iv[k] = 1'b0;
         if (clr) begin
            m_inwin[k] = 0; m_tot[k] = 0; m_armed[k] = 1'b0;
         end else if (en) begin
            m_ecyc[k]++;
            if (ev) begin
               m_tot[k]++;
`ifdef QIF_SPIKE_DEC_ISI_EN
               if (m_armed[k]) begin
                  d = m_ecyc[k] - m_last[k];
                  m_isi[k] = (d > isi_max(k)) ? isi_max(k) : d;
                  m_iv[k] = 1'b1;
               end
`endif
               m_armed[k] = 1'b1;
               m_last[k] = m_ecyc[k];
            end
            m_inwin[k]++;
            if (m_inwin[k] == win_len(k)) begin
               m_rate[k] = (m_tot[k] > 255) ? 255 : m_tot[k];
               m_sat[k] = (m_tot[k] >= 255);
               m_rv[k] = 1'b1;
               m_tot[k] = 0;
               m_inwin[k] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b1; clr = 1'b0;
      for (int c = 0; c < 40; c++) begin
         spike = ($urandom_range(0, 2) == 0);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (act_vec(k) !== exp_vec(k)) begin
               bad++;
               $display("FAIL reset_pre dut%0d cyc%0d got=%h want=%h", k, c, act_vec(k), exp_vec(k));
            end
         end
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (act_vec(k) !== 27'd0) begin
            bad++;
            $display("FAIL reset_async dut%0d got=%h want=0", k, act_vec(k));
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_rate();
      int pulses;
      do_reset();
      en = 1'b1; clr = 1'b0; pulses = 0;
      for (int c = 0; c < 64; c++) begin
         spike = (c % 4 == 1);
         tick();
         total++;
         if (act_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL rate_model cyc%0d got=%h want=%h", c, act_vec(0), exp_vec(0));
         end
         if (rv_a) begin
            pulses++;
            total++;
            if (rate_a !== 8'd4 || sat_a !== 1'b0 || (c % 16) != 15) begin
               bad++;
               $display("FAIL rate_value cyc%0d got rate=%0d sat=%0b want rate=4 sat=0 at cyc%%16=15", c, rate_a, sat_a);
            end
         end
      end
      total++;
      if (pulses != 4) begin
         bad++;
         $display("FAIL rate_pulses got=%0d want=4", pulses);
      end
   endtask

   task automatic test_level();
      spike = 1'b1;
      do_reset();
      en = 1'b1; clr = 1'b0;
      for (int c = 0; c < 16; c++) begin
         spike = (c < 3) || (c >= 4 && c < 14);
         tick();
         total++;
         if (act_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL level_model cyc%0d got=%h want=%h", c, act_vec(0), exp_vec(0));
         end
      end
      total++;
      if (rv_a !== 1'b1 || rate_a !== 8'd1) begin
         bad++;
         $display("FAIL level_count got rv=%0b rate=%0d want rv=1 rate=1", rv_a, rate_a);
      end
   endtask

   task automatic test_isi();
      do_reset();
      en = 1'b1; clr = 1'b0;
      for (int c = 0; c < 16; c++) begin
         spike = (c == 2) || (c == 9) || (c == 12);
         tick();
         total++;
         if (act_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL isi_model cyc%0d got=%h want=%h", c, act_vec(0), exp_vec(0));
         end
`ifdef QIF_SPIKE_DEC_ISI_EN
         if (c == 2 || c == 9 || c == 10 || c == 12) begin
            total++;
            if (iv_a !== (c == 9 || c == 12) || (c == 9 && isi_a !== 16'd7) || (c == 12 && isi_a !== 16'd3)) begin
               bad++;
               $display("FAIL isi_value cyc%0d got isi=%0d iv=%0b", c, isi_a, iv_a);
            end
         end
`else
         total++;
         if (isi_a !== 16'd0 || iv_a !== 1'b0) begin
            bad++;
            $display("FAIL isi_tied cyc%0d got isi=%0d iv=%0b want 0 0", c, isi_a, iv_a);
         end
`endif
      end
   endtask

   task automatic test_saturation();
      int pulses_b;
      do_reset();
      en = 1'b1; clr = 1'b0; pulses_b = 0;
      for (int c = 0; c < 2048; c++) begin
         spike = (c % 2 == 1);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (act_vec(k) !== exp_vec(k)) begin
               bad++;
               $display("FAIL sat_model dut%0d cyc%0d got=%h want=%h", k, c, act_vec(k), exp_vec(k));
            end
         end
         if (rv_b) begin
            pulses_b++;
            total++;
            if (rate_b !== 8'd255 || sat_b !== 1'b1) begin
               bad++;
               $display("FAIL sat_value got rate=%0d sat=%0b want rate=255 sat=1", rate_b, sat_b);
            end
         end
      end
      total++;
      if (pulses_b != 2) begin
         bad++;
         $display("FAIL sat_pulses got=%0d want=2", pulses_b);
      end
      for (int c = 0; c < 50; c++) begin
         spike = (c % 20 == 5);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (act_vec(k) !== exp_vec(k)) begin
               bad++;
               $display("FAIL isi_sat_model dut%0d cyc%0d got=%h want=%h", k, c, act_vec(k), exp_vec(k));
            end
         end
`ifdef QIF_SPIKE_DEC_ISI_EN
         if (c == 25 || c == 45) begin
            total++;
            if (isi_b !== 4'd15 || iv_b !== 1'b1 || isi_a !== 16'd20 || iv_a !== 1'b1) begin
               bad++;
               $display("FAIL isi_sat cyc%0d got b=%0d/%0b a=%0d/%0b want b=15/1 a=20/1", c, isi_b, iv_b, isi_a, iv_a);
            end
         end
`endif
      end
   endtask

   task automatic test_clr_en();
      int n;
      do_reset();
      en = 1'b1; clr = 1'b0; spike = 1'b0;
      for (int c = 0; c < 15; c++) begin
         spike = ($urandom_range(0, 1) == 1);
         tick();
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      total++;
      if (rv_a !== 1'b0 || act_vec(0) !== exp_vec(0)) begin
         bad++;
         $display("FAIL clr_close got rv=%0b vec=%h want rv=0 vec=%h", rv_a, act_vec(0), exp_vec(0));
      end
      n = 0;
      do begin
         spike = ($urandom_range(0, 1) == 1);
         tick();
         n++;
      end while (!rv_a && n < 40);
      total++;
      if (n != 16 || act_vec(0) !== exp_vec(0)) begin
         bad++;
         $display("FAIL clr_next_window got len=%0d vec=%h want len=16 vec=%h", n, act_vec(0), exp_vec(0));
      end
      spike = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int c = 0; c < 8; c++) begin
         spike = (c == 3);
         tick();
      end
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         spike = (c % 2 == 0);
         tick();
      end
      en = 1'b1; spike = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rv_a && n < 40);
      total++;
      if (n != 8 || rate_a !== 8'd1 || act_vec(0) !== exp_vec(0)) begin
         bad++;
         $display("FAIL en_gap got len=%0d rate=%0d want len=8 rate=1", n, rate_a);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1200; c++) begin
         en    = ($urandom_range(0, 9) != 0);
         clr   = ($urandom_range(0, 79) == 0);
         spike = ($urandom_range(0, 2) == 0);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (act_vec(k) !== exp_vec(k)) begin
               bad++;
               $display("FAIL random dut%0d cyc%0d got=%h want=%h", k, c, act_vec(k), exp_vec(k));
            end
         end
      end
      en = 1'b1; clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; spike = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_rate();
      test_level();
      test_isi();
      test_saturation();
      test_clr_en();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qif_spike_decoder.md
# qif_spike_decoder

Receive-side companion to the QIF neuron tile: it consumes the neuron's single-bit spike output and decodes it back into numeric form. It produces a windowed firing-rate estimate and, optionally, the inter-spike interval. Typical placement is downstream of a neuron, either to drive the next stage's 8-bit input current or to be read out on the tile's bidirectional pins.

## Interface
Parameters:
- WINDOW_LOG2, default 8: rate window length is 2^WINDOW_LOG2 enabled cycles; legal range 2..16.
- ISI_W, default 16: width of the inter-spike-interval counter and output.

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  count enable; when low, all counters and the FSM hold their values.
- clr  in  1  synchronous clear of the window and ISI state; output registers keep their last values.
- spike_in  in  1  spike level from the neuron; may stay high for several cycles.
- rate  out  8  spike count of the last completed window, saturating.
- rate_valid  out  1  one-cycle pulse when rate updates.
- rate_sat  out  1  set when the last completed window's count saturated.
- isi  out  ISI_W  cycles between the last two spike edges, saturating.
- isi_valid  out  1  one-cycle pulse when isi updates.

## Operation
- Edge detect: register spike_prev, reset value 1, so a level held high through reset does not count. A spike event is spike_in=1 with spike_prev=0, sampled at a clock edge. spike_prev updates every cycle regardless of en or clr, so re-enabling never creates a false edge.
- Rate path: win_cnt is WINDOW_LOG2 bits wide and spk_cnt is 9 bits wide, saturating at 255. Both advance only while en=1.
  - Window-closing cycle: en=1 and win_cnt is all-ones.
  - In that cycle, rate <= min(spk_cnt + event, 255), rate_sat <= (result == 255 reached by saturation), rate_valid <= 1, spk_cnt <= 0, and win_cnt wraps to 0. An event in the closing cycle belongs to the closing window.
- ISI FSM (two states):
  - IDLE: waits for the first event, then goes to ARMED with isi_cnt=1.
  - ARMED, per enabled cycle with no event: isi_cnt increments, saturating at 2^ISI_W-1.
  - ARMED, on an event: isi <= isi_cnt, isi_valid <= 1, isi_cnt <= 1, stays in ARMED.
  - The first event after reset or clr never produces isi_valid.
- clr: takes priority over events and window close in the same cycle. It sets win_cnt=0, spk_cnt=0, isi_cnt=0 and FSM=IDLE. No valid pulse is generated.
- en=0: no events are counted, no window closes, and isi_cnt does not advance.

## Timing
- Reset values: rate=0, rate_valid=0, rate_sat=0, isi=0, isi_valid=0, FSM=IDLE, spike_prev=1, all counters 0.
- rate, rate_sat and rate_valid are all registered and change on the clock edge that processes the closing cycle. rate_valid is high for exactly one cycle.
- With en held high, a window spans exactly 2^WINDOW_LOG2 cycles, and rate_valid has period 2^WINDOW_LOG2.
- isi and isi_valid are registered on the same edge that samples the second event. Latency from spike_in rising to isi_valid is 1 clock.
- With en held high, two events sampled k cycles apart give isi=k.
- Reset asserted mid-window forces the reset values immediately. The first window after release is a full 2^WINDOW_LOG2 cycles.

## Configuration
- QIF_SPIKE_DEC_ISI_EN defined: the ISI FSM, isi_cnt and the isi and isi_valid registers are compiled in as described above.
- QIF_SPIKE_DEC_ISI_EN undefined: isi is tied to 0 and isi_valid to 0, with no ISI logic. The rate path is unchanged.

## Test plan
- Reset: drive rst_n low mid-operation -> every output reads its reset value in the same cycle, with no clock required.
- Rate: WINDOW_LOG2=4, en=1, 1-cycle spike every 4 cycles -> rate=4 with a 1-cycle rate_valid every 16 cycles, rate_sat=0.
- Level handling: spike_in held high for 10 cycles inside one window, and spike_in high through reset release -> the held pulse counts once and the reset-held level counts zero times.
- ISI (macro defined): events 7 cycles apart, then 3 cycles apart -> no isi_valid on the first event, then isi=7, then isi=3, each with a 1-cycle isi_valid.
- Saturation: WINDOW_LOG2=10, spike_in toggling every cycle (512 events) -> rate=255, rate_sat=1. With ISI_W=4 and events 20 apart -> isi=15.
- clr and en: clr in the window-closing cycle -> no rate_valid and the next window is full length. en low for 5 cycles mid-window -> window close delayed by exactly 5 cycles, and spikes during that gap are not counted.
